mem_port_arbiter: RTL and testbench

//  Shares the single unified instruction/data byte memory between two requesters:
//   - the fetch stage (32-bit instruction reads),
//   - the memory stage (64-bit loads/stores, including call/return stack traffic).

---
 rtl/tinker_pkg.sv | 20 ++
 rtl/arb_lat_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_pkg.sv
// Shared types and widths for the tinker_core memory port arbiter.
// Holds the arbiter FSM state and transaction owner encodings.
package tinker_pkg;

    localparam int INSTR_W = 32;
    localparam int WORD_W  = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } arb_owner_t;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter for the arbiter WAIT state.
// o_done fires on the last enabled cycle of the loaded count.
module arb_lat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = i_en && (r_cnt == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of the unified byte memory, data priority.
// Optional fetch starvation guard: define FETCH_STARVE_GUARD_EN.
module mem_port_arbiter
    import tinker_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_rsp_valid,
    output logic [INSTR_W-1:0]  if_rsp_instr,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [WORD_W-1:0]   d_req_wdata,
    output logic                d_rsp_valid,
    output logic [WORD_W-1:0]   d_rsp_rdata,
    output logic                d_rsp_err,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    input  logic [WORD_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int CNT_W = 3;

    arb_state_t          r_state;
    arb_state_t          w_next;
    arb_owner_t          r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_wdata;
    logic                w_idle;
    logic                w_grant_f;
    logic                w_grant_d;
    logic                w_lat_done;
    logic                w_resp;

    assign w_idle = (r_state == IDLE) && !reset;

`ifdef FETCH_STARVE_GUARD_EN
    logic [2:0] r_starve;
    logic       w_force;

    assign w_force   = (r_starve >= 3'(STARVE_MAX));
    assign w_grant_f = if_req_valid && (!d_req_valid || w_force);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_idle && w_grant_f) begin
            r_starve <= '0;
        end else if (w_idle && w_grant_d && if_req_valid
                     && (r_starve != 3'd7)) begin
            r_starve <= r_starve + 3'd1;
        end
    end
`else
    assign w_grant_f = if_req_valid && !d_req_valid;
`endif

    assign w_grant_d    = d_req_valid && !w_grant_f;
    assign if_req_ready = w_idle && w_grant_f;
    assign d_req_ready  = w_idle && w_grant_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request fields stay put until the next handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= OWN_FETCH;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (d_req_ready) begin
            r_owner <= OWN_DATA;
            r_we    <= d_req_we;
            r_addr  <= d_req_addr;
            r_wdata <= d_req_wdata;
        end else if (if_req_ready) begin
            r_owner <= OWN_FETCH;
            r_we    <= 1'b0;
            r_addr  <= if_req_addr;
            r_wdata <= '0;
        end
    end

    arb_lat_counter #(
        .W (CNT_W)
    ) u_lat (
        .clk        (clk),
        .reset      (reset),
        .i_load     (r_state == ACCESS),
        .i_load_val (CNT_W'(MEM_LAT - 1)),
        .i_en       (r_state == WAIT),
        .o_done     (w_lat_done)
    );

    always_comb begin
        w_next       = r_state;
        w_resp       = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = r_addr;
        mem_wdata    = r_wdata;
        busy         = (r_state != IDLE);
        if_rsp_valid = 1'b0;
        if_rsp_instr = '0;
        d_rsp_valid  = 1'b0;
        d_rsp_rdata  = '0;
        d_rsp_err    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (if_req_ready || d_req_ready) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = r_we;
                w_next = (MEM_LAT == 1) ? RESP : WAIT;
            end
            WAIT: begin
                mem_we = r_we;
                if (w_lat_done) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                mem_we = r_we;
                w_resp = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (w_resp && (r_owner == OWN_FETCH)) begin
            if_rsp_valid = 1'b1;
            if_rsp_instr = mem_rdata[INSTR_W-1:0];
        end
        if (w_resp && (r_owner == OWN_DATA)) begin
            d_rsp_valid = 1'b1;
            d_rsp_rdata = r_we ? '0 : mem_rdata;
            d_rsp_err   = (r_addr[2:0] != 3'd0);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1,
// one at MEM_LAT=3, each with its own byte-memory model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic        a_if_valid = 0, a_if_ready, a_if_rsp_valid;
    logic [63:0] a_if_addr = 0;
    logic [31:0] a_if_rsp_instr;
    logic        a_d_valid = 0, a_d_ready, a_d_we = 0;
    logic [63:0] a_d_addr = 0, a_d_wdata = 0, a_d_rsp_rdata;
    logic        a_d_rsp_valid, a_d_rsp_err;
    logic        a_mem_en, a_mem_we, a_busy;
    logic [63:0] a_mem_addr, a_mem_wdata, a_rdata;

    logic        b_if_ready, b_if_rsp_valid;
    logic [31:0] b_if_rsp_instr;
    logic        b_d_valid = 0, b_d_ready;
    logic [63:0] b_d_addr = 0, b_d_rsp_rdata;
    logic        b_d_rsp_valid, b_d_rsp_err;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [63:0] b_mem_addr, b_mem_wdata, b_rdata, b_p1, b_p2;

    mem_port_arbiter #(.ADDR_W(64), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_a (
        .clk(clk), .reset(reset),
        .if_req_valid(a_if_valid), .if_req_ready(a_if_ready),
        .if_req_addr(a_if_addr), .if_rsp_valid(a_if_rsp_valid),
        .if_rsp_instr(a_if_rsp_instr),
        .d_req_valid(a_d_valid), .d_req_ready(a_d_ready),
        .d_req_we(a_d_we), .d_req_addr(a_d_addr),
        .d_req_wdata(a_d_wdata), .d_rsp_valid(a_d_rsp_valid),
        .d_rsp_rdata(a_d_rsp_rdata), .d_rsp_err(a_d_rsp_err),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_rdata), .busy(a_busy)
    );

    mem_port_arbiter #(.ADDR_W(64), .MEM_LAT(3), .STARVE_MAX(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .if_req_valid(1'b0), .if_req_ready(b_if_ready),
        .if_req_addr(64'd0), .if_rsp_valid(b_if_rsp_valid),
        .if_rsp_instr(b_if_rsp_instr),
        .d_req_valid(b_d_valid), .d_req_ready(b_d_ready),
        .d_req_we(1'b0), .d_req_addr(b_d_addr),
        .d_req_wdata(64'd0), .d_rsp_valid(b_d_rsp_valid),
        .d_rsp_rdata(b_d_rsp_rdata), .d_rsp_err(b_d_rsp_err),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_rdata), .busy(b_busy)
    );

    // Byte memories, little-endian, with a backdoor preload port.
    logic [7:0]  mem_a [0:(1<<20)-1];
    logic [7:0]  mem_b [0:(1<<20)-1];
    logic        pl_en = 0, pl_sel = 0;
    logic [19:0] pl_addr = 0;
    logic [63:0] pl_data = 0;

    always @(posedge clk) begin
        if (a_mem_en && a_mem_we) begin
            for (int i = 0; i < 8; i++)
                mem_a[a_mem_addr[19:0] + 20'(i)] <= a_mem_wdata[8*i +: 8];
        end else if (pl_en && !pl_sel) begin
            for (int i = 0; i < 8; i++)
                mem_a[pl_addr + 20'(i)] <= pl_data[8*i +: 8];
        end
        if (a_mem_en) begin
            for (int i = 0; i < 8; i++)
                a_rdata[8*i +: 8] <= mem_a[a_mem_addr[19:0] + 20'(i)];
        end else begin
            a_rdata <= '0;
        end
    end

    always @(posedge clk) begin
        if (pl_en && pl_sel) begin
            for (int i = 0; i < 8; i++)
                mem_b[pl_addr + 20'(i)] <= pl_data[8*i +: 8];
        end
        if (b_mem_en) begin
            for (int i = 0; i < 8; i++)
                b_p1[8*i +: 8] <= mem_b[b_mem_addr[19:0] + 20'(i)];
        end else begin
            b_p1 <= '0;
        end
        b_p2    <= b_p1;
        b_rdata <= b_p2;
    end

    task automatic preload(input logic sel, input logic [19:0] addr,
                           input logic [63:0] data);
        @(negedge clk);
        pl_en = 1; pl_sel = sel; pl_addr = addr; pl_data = data;
        @(negedge clk);
        pl_en = 0;
    endtask

    task automatic a_fetch(input logic [63:0] addr, output int lat,
                           output logic [31:0] ins);
        @(negedge clk);
        a_if_valid = 1; a_if_addr = addr;
        #1 check("if_ready", 64'(a_if_ready), 64'd1);
        @(negedge clk);
        a_if_valid = 0;
        lat = -1; ins = '0;
        for (int k = 1; k <= 6; k++) begin
            #1;
            if (a_if_rsp_valid && lat < 0) begin
                lat = k; ins = a_if_rsp_instr;
            end
            @(negedge clk);
        end
    endtask

    task automatic a_data(input logic we, input logic [63:0] addr,
                          input logic [63:0] wd, output int lat,
                          output logic [63:0] rd, output logic err,
                          output int wecyc);
        @(negedge clk);
        a_d_valid = 1; a_d_we = we; a_d_addr = addr; a_d_wdata = wd;
        #1 check("d_ready", 64'(a_d_ready), 64'd1);
        @(negedge clk);
        a_d_valid = 0;
        lat = -1; rd = '0; err = 0; wecyc = 0;
        for (int k = 1; k <= 6; k++) begin
            #1;
            if (a_mem_en && a_mem_we) wecyc++;
            if (a_d_rsp_valid && lat < 0) begin
                lat = k; rd = a_d_rsp_rdata; err = a_d_rsp_err;
            end
            @(negedge clk);
        end
    endtask

    task automatic b_load(input logic [63:0] addr, output int lat,
                          output logic [63:0] rd);
        @(negedge clk);
        b_d_valid = 1; b_d_addr = addr;
        #1 check("b_d_ready", 64'(b_d_ready), 64'd1);
        @(negedge clk);
        b_d_valid = 0;
        lat = -1; rd = '0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (b_d_rsp_valid && lat < 0) begin
                lat = k; rd = b_d_rsp_rdata;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int          lat, wc, dk, ik, pulses, nd_first, nif;
        logic [63:0] rd;
        logic [31:0] ins;
        logic        err, drop;

        // Reset: readys held low even with both requesters valid.
        a_if_valid = 1; a_d_valid = 1;
        #2;
        check("rst_if_ready", 64'(a_if_ready), 64'd0);
        check("rst_d_ready", 64'(a_d_ready), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_mem_en", 64'(a_mem_en), 64'd0);
        check("rst_mem_we", 64'(a_mem_we), 64'd0);
        check("rst_mem_addr", a_mem_addr, 64'd0);
        check("rst_mem_wdata", a_mem_wdata, 64'd0);
        check("rst_rsp", 64'({a_if_rsp_valid, a_d_rsp_valid}), 64'd0);
        check("rst_rdata", a_d_rsp_rdata, 64'd0);
        a_if_valid = 0; a_d_valid = 0;
        preload(0, 20'h02000, 64'h0000_0013_8C40_0004);
        preload(0, 20'h80000, 64'h0123_4567_89AB_CDEF);
        preload(1, 20'h00100, 64'hDEAD_BEEF_0000_0001);
        @(negedge clk);
        reset = 0;

        // Idle fetch.
        a_fetch(64'h2000, lat, ins);
        check("t1_lat", 64'(lat), 64'd2);
        check("t1_instr", 64'(ins), 64'h8C40_0004);
        check("t1_idle", 64'(a_busy), 64'd0);

        // Simultaneous fetch and load.
        @(negedge clk);
        a_if_valid = 1; a_if_addr = 64'h2004;
        a_d_valid = 1; a_d_we = 0; a_d_addr = 64'h80000;
        #1;
        check("t2_d_ready", 64'(a_d_ready), 64'd1);
        check("t2_if_ready", 64'(a_if_ready), 64'd0);
        @(negedge clk);
        a_d_valid = 0;
        dk = -1; ik = -1; drop = 0; rd = '0; ins = '0;
        for (int k = 1; k <= 8; k++) begin
            if (drop) a_if_valid = 0;
            #1;
            if (k == 1) check("t2_busy_if_ready", 64'(a_if_ready), 64'd0);
            if (a_d_rsp_valid && dk < 0) begin
                dk = k; rd = a_d_rsp_rdata;
            end
            if (a_if_rsp_valid && ik < 0) begin
                ik = k; ins = a_if_rsp_instr;
            end
            if (a_if_ready) drop = 1;
            @(negedge clk);
        end
        a_if_valid = 0;
        check("t2_d_lat", 64'(dk), 64'd2);
        check("t2_d_rdata", rd, 64'h0123_4567_89AB_CDEF);
        check("t2_if_lat", 64'(ik), 64'd5);
        check("t2_instr", 64'(ins), 64'h0000_0013);

        // Store then load back.
        a_data(1, 64'h7FFF8, 64'h1234, lat, rd, err, wc);
        check("t3_st_lat", 64'(lat), 64'd2);
        check("t3_st_we_cycles", 64'(wc), 64'd1);
        check("t3_st_rdata", rd, 64'd0);
        check("t3_st_err", 64'(err), 64'd0);
        a_data(0, 64'h7FFF8, 64'h0, lat, rd, err, wc);
        check("t3_ld_lat", 64'(lat), 64'd2);
        check("t3_ld_rdata", rd, 64'h1234);
        check("t3_ld_we_cycles", 64'(wc), 64'd0);

        // Misaligned load.
        a_data(0, 64'h7FFF3, 64'h0, lat, rd, err, wc);
        check("t4_lat", 64'(lat), 64'd2);
        check("t4_err", 64'(err), 64'd1);

        // Longer latency, then reset while waiting.
        b_load(64'h100, lat, rd);
        check("t5_lat3", 64'(lat), 64'd4);
        check("t5_rdata", rd, 64'hDEAD_BEEF_0000_0001);
        @(negedge clk);
        b_d_valid = 1; b_d_addr = 64'h100;
        @(negedge clk);
        b_d_valid = 0;
        @(negedge clk);
        #1;
        check("t5_wait_busy", 64'(b_busy), 64'd1);
        check("t5_wait_mem_en", 64'(b_mem_en), 64'd0);
        reset = 1; b_d_valid = 1;
        #1;
        check("t5_rst_busy", 64'(b_busy), 64'd0);
        check("t5_rst_ready", 64'(b_d_ready), 64'd0);
        check("t5_rst_mem_addr", b_mem_addr, 64'd0);
        check("t5_rst_mem_en", 64'({b_mem_en, b_mem_we}), 64'd0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 2) begin
                reset = 0; b_d_valid = 0;
            end
            #1;
            if (b_d_rsp_valid || b_busy) pulses++;
        end
        check("t5_no_rsp", 64'(pulses), 64'd0);
        b_load(64'h100, lat, rd);
        check("t5_after_lat", 64'(lat), 64'd4);
        check("t5_after_rdata", rd, 64'hDEAD_BEEF_0000_0001);

        // Continuous contention.
        @(negedge clk);
        a_if_valid = 1; a_if_addr = 64'h2004;
        a_d_valid = 1; a_d_we = 0; a_d_addr = 64'h80000;
        nd_first = 0; nif = 0;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (a_d_ready && nif == 0) nd_first++;
            if (a_if_ready) nif++;
            @(negedge clk);
        end
        a_if_valid = 0; a_d_valid = 0;
`ifdef FETCH_STARVE_GUARD_EN
        check("t6_d_before_f", 64'(nd_first), 64'd4);
        check("t6_f_grants", 64'(nif), 64'd2);
`else
        check("t6_d_before_f", 64'(nd_first), 64'd10);
        check("t6_f_grants", 64'(nif), 64'd0);
`endif
        repeat (4) @(negedge clk);
        #1 check("t6_drain_busy", 64'(a_busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
